// File: rtl/hs32_mem_pkg.sv
// Shared types and widths for the HS32 SRAM bank arbiter.
package hs32_mem_pkg;

  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = 4;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    WB_RSP = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_WB  = 1'b1
  } req_id_t;

endpackage

// File: rtl/hs32_arb_pick.sv
// Purpose: one-of-two grant decision for the shared SRAM port (CPU vs Wishbone).
// Latency: purely combinational, grant in the request cycle.
// Backpressure: the loser simply sees no grant and keeps requesting.
module hs32_arb_pick
  import hs32_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             cpu_vld,
  input  logic             wb_vld,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             last_wb,
  output logic             gnt_cpu,
  output logic             gnt_wb
);

  req_id_t winner;
  logic    unused_sel;

  // Only one of starve_cnt / last_wb matters in a given build.
  assign unused_sel = ^{starve_cnt, last_wb};

  always_comb begin
    winner = REQ_CPU;
`ifdef HS32_SRAM_ARB_RR_EN
    if (cpu_vld && wb_vld) begin
      winner = last_wb ? REQ_CPU : REQ_WB;
    end else if (wb_vld) begin
      winner = REQ_WB;
    end
`else
    if (cpu_vld && wb_vld) begin
      winner = (starve_cnt == CNT_W'(STARVE_MAX)) ? REQ_WB : REQ_CPU;
    end else if (wb_vld) begin
      winner = REQ_WB;
    end
`endif
    gnt_cpu = cpu_vld && (winner == REQ_CPU);
    gnt_wb  = wb_vld && (winner == REQ_WB);
  end

endmodule

// File: rtl/hs32_sram_arbiter.sv
// Purpose: shares one 1rw SRAM macro between the HS32 core port and a Wishbone slave.
// Latency: CPU read data 1 cycle after grant; WB ack 2 cycles after issue (1 if out of window).
// Backpressure: CPU holds cpu_req until cpu_gnt; WB waits on ack. HS32_SRAM_ARB_RR_EN selects round-robin.
module hs32_sram_arbiter
  import hs32_mem_pkg::*;
#(
  parameter int          AW         = 8,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000,
  parameter int          STARVE_MAX = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [SRAM_MW-1:0] cpu_wmask,
  input  logic [SRAM_DW-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [SRAM_DW-1:0] cpu_rdata,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [SRAM_MW-1:0] wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [SRAM_DW-1:0] wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [SRAM_DW-1:0] wbs_dat_o,
  output logic               sram_csb,
  output logic               sram_web,
  output logic [SRAM_MW-1:0] sram_wmask,
  output logic [AW-1:0]      sram_addr,
  output logic [SRAM_DW-1:0] sram_din,
  input  logic [SRAM_DW-1:0] sram_dout
);

  arb_state_t       state_q;
  logic             wb_rd_q;
  logic             wb_req, wb_hit, wb_vld, wb_oow;
  logic             gnt_cpu, gnt_wb;
  logic [CNT_W-1:0] starve_cnt;
  logic             last_wb;
  logic             unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign wb_req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wb_hit = (wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);
  assign wb_vld = wb_req && wb_hit && (state_q == IDLE);
  assign wb_oow = wb_req && !wb_hit && (state_q == IDLE);

  // Gating with reset keeps the combinational outputs at reset values during reset.
  hs32_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .cpu_vld   (cpu_req && wb_rst_ni),
    .wb_vld    (wb_vld && wb_rst_ni),
    .starve_cnt(starve_cnt),
    .last_wb   (last_wb),
    .gnt_cpu   (gnt_cpu),
    .gnt_wb    (gnt_wb)
  );

  assign cpu_gnt   = gnt_cpu;
  assign cpu_rdata = cpu_rvalid ? sram_dout : '0;

  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (gnt_cpu) begin
      sram_csb   = 1'b0;
      sram_web   = !cpu_we;
      sram_wmask = cpu_wmask;
      sram_addr  = cpu_addr;
      sram_din   = cpu_wdata;
    end else if (gnt_wb) begin
      sram_csb   = 1'b0;
      sram_web   = !wbs_we_i;
      sram_wmask = wbs_sel_i;
      sram_addr  = wbs_adr_i[AW+1:2];
      sram_din   = wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      wb_rd_q    <= 1'b0;
      cpu_rvalid <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
    end else begin
      cpu_rvalid <= gnt_cpu && !cpu_we;
      wbs_ack_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_wb) begin
            state_q <= WB_RSP;
            wb_rd_q <= !wbs_we_i;
          end else if (wb_oow) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= '0;
          end
        end
        WB_RSP: begin
          state_q <= IDLE;
          // A master that abandoned the cycle gets neither ack nor data.
          if (wbs_cyc_i) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wb_rd_q ? sram_dout : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HS32_SRAM_ARB_RR_EN
  req_id_t last_q;

  assign starve_cnt = '0;
  assign last_wb    = (last_q == REQ_WB);

  // Starts as WB so the first contended cycle goes to the CPU.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      last_q <= REQ_WB;
    end else if (gnt_wb) begin
      last_q <= REQ_WB;
    end else if (gnt_cpu) begin
      last_q <= REQ_CPU;
    end
  end
`else
  logic [CNT_W-1:0] cnt_q;

  assign starve_cnt = cnt_q;
  assign last_wb    = 1'b0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else if (gnt_wb || !wb_vld) begin
      cnt_q <= '0;
    end else if (gnt_cpu) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule
